// File: rtl/vp_pkg.sv
// Shared definitions for the video-pipeline blocks.
//   tpg_mode_e  : test-pattern selector (bars, ramp, checkerboard, solid)
//   tpg_state_e : pattern-source run state
//   BAR_RGB     : colour-bar table, entry 0 is the leftmost bar
package vp_pkg;

    typedef enum logic [1:0] {
        TPG_BARS  = 2'd0,
        TPG_RAMP  = 2'd1,
        TPG_CHECK = 2'd2,
        TPG_SOLID = 2'd3
    } tpg_mode_e;

    typedef enum logic {
        TPG_IDLE = 1'b0,
        TPG_RUN  = 1'b1
    } tpg_state_e;

    localparam int unsigned CNT_W = 12;

    // Packed so that BAR_RGB[i] is bar i; the last listed element is index 0.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/vtiming_cnt.sv
// Raster timing counters: 12-bit horizontal/vertical position, active-area
// and vsync decode, and a strobe on the last position of the frame.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   run_i        : advance the counters this cycle
//   h_cnt_o      : pixel position within the line (0..H_TOTAL-1)
//   v_cnt_o      : line position within the frame (0..V_TOTAL-1)
//   active_o     : current position is inside the displayed image
//   vs_o         : current line is inside the vsync window
//   frame_end_o  : current position is the last one of the frame
// Outputs are combinational decodes of the counter registers.
module vtiming_cnt
    import vp_pkg::*;
#(
    parameter logic [11:0] IMG_HDISP = 12'd1280,
    parameter logic [11:0] IMG_VDISP = 12'd720,
    parameter logic [11:0] H_BLANK   = 12'd370,
    parameter logic [11:0] V_FP      = 12'd5,
    parameter logic [11:0] V_SYNC    = 12'd5,
    parameter logic [11:0] V_BP      = 12'd20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    output logic [CNT_W-1:0]  h_cnt_o,
    output logic [CNT_W-1:0]  v_cnt_o,
    output logic              active_o,
    output logic              vs_o,
    output logic              frame_end_o
);

    localparam int unsigned H_TOT = 32'(IMG_HDISP) + 32'(H_BLANK);
    localparam int unsigned V_TOT = 32'(IMG_VDISP) + 32'(V_FP) + 32'(V_SYNC) + 32'(V_BP);

    if (H_TOT > 4095 || V_TOT > 4095 || H_TOT == 0 || V_TOT == 0) begin : g_bad_timing
        $error("vtiming_cnt: H_TOTAL and V_TOTAL must be in 1..4095");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(32'(IMG_VDISP) + 32'(V_FP));
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(32'(IMG_VDISP) + 32'(V_FP) + 32'(V_SYNC));

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last;
    logic             v_last;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (run_i) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign active_o    = (h_cnt_q < IMG_HDISP) && (v_cnt_q < IMG_VDISP);
    assign vs_o        = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/video_tpg.sv
// Video test-pattern source producing a vs/de/RGB888 stream.
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   EN          : run request, acted on only at frame boundaries
//   mode        : 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
//   solid_rgb   : {R,G,B} for the solid pattern
//   post_vs     : vertical sync, active high
//   post_de     : pixel valid
//   post_data   : pixel {R,G,B}, zero outside the active area
//   frame_done  : one-cycle pulse for the last position of each frame
// All outputs are registered one cycle behind the counter position.
module video_tpg
    import vp_pkg::*;
#(
    parameter logic [11:0] IMG_HDISP = 12'd1280,
    parameter logic [11:0] IMG_VDISP = 12'd720,
    parameter logic [11:0] H_BLANK   = 12'd370,
    parameter logic [11:0] V_FP      = 12'd5,
    parameter logic [11:0] V_SYNC    = 12'd5,
    parameter logic [11:0] V_BP      = 12'd20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic        post_vs,
    output logic        post_de,
    output logic [23:0] post_data,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] BAR_W    = IMG_HDISP >> 3;
    localparam logic [CNT_W-1:0] BAR_W_M1 = BAR_W - 12'd1;

    tpg_state_e        state_q, state_d;
    logic              run;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              active;
    logic              vs;
    logic              frame_end;
    logic              frame_start;

    tpg_mode_e         mode_sh_q;
    logic [23:0]       rgb_sh_q;
    tpg_mode_e         cur_mode;
    logic [23:0]       cur_rgb;

    logic [2:0]        bar_idx_q, bar_idx_d, bar_idx_cur;
    logic [CNT_W-1:0]  bar_px_q, bar_px_d, bar_px_cur;
    logic [23:0]       pix;

    logic              vs_q, de_q, fd_q;
    logic [23:0]       data_q;

    vtiming_cnt #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_BLANK   (H_BLANK),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .vs_o        (vs),
        .frame_end_o (frame_end)
    );

    assign run = (state_q == TPG_RUN);

    // Run state: leaving RUN is only possible on the frame's last position.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TPG_IDLE: if (EN) state_d = TPG_RUN;
            TPG_RUN:  if (frame_end && !EN) state_d = TPG_IDLE;
            default:  state_d = TPG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= TPG_IDLE;
        else        state_q <= state_d;
    end

    // Shadow registers load at (0,0); the bypass lets pixel 0 of the new
    // frame already use the freshly sampled settings.
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    assign cur_mode    = frame_start ? tpg_mode_e'(mode) : mode_sh_q;
    assign cur_rgb     = frame_start ? solid_rgb : rgb_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh_q <= TPG_BARS;
            rgb_sh_q  <= '0;
        end else if (frame_start) begin
            mode_sh_q <= tpg_mode_e'(mode);
            rgb_sh_q  <= solid_rgb;
        end
    end

    // Bar index tracks h_cnt: registers hold the value for the current
    // position, forced to bar 0 whenever h_cnt is 0.
    assign bar_idx_cur = (h_cnt == '0) ? 3'd0 : bar_idx_q;
    assign bar_px_cur  = (h_cnt == '0) ? '0 : bar_px_q;

    always_comb begin
        bar_idx_d = bar_idx_cur;
        bar_px_d  = bar_px_cur + 12'd1;
        if (bar_px_cur == BAR_W_M1) begin
            bar_px_d  = '0;
            bar_idx_d = (bar_idx_cur == 3'd7) ? 3'd7 : bar_idx_cur + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx_q <= '0;
            bar_px_q  <= '0;
        end else begin
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
        end
    end

    always_comb begin
        pix = '0;
        case (cur_mode)
            TPG_BARS:  pix = BAR_RGB[bar_idx_cur];
            TPG_RAMP:  pix = {3{h_cnt[7:0]}};
            TPG_CHECK: pix = (h_cnt[5] ^ v_cnt[5]) ? '1 : '0;
            TPG_SOLID: pix = cur_rgb;
            default:   pix = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            data_q <= '0;
            fd_q   <= 1'b0;
        end else if (run) begin
            vs_q   <= vs;
            de_q   <= active;
            data_q <= active ? pix : '0;
            fd_q   <= frame_end;
        end else begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            data_q <= '0;
            fd_q   <= 1'b0;
        end
    end

    assign post_vs    = vs_q;
    assign post_de    = de_q;
    assign post_data  = data_q;
    assign frame_done = fd_q;

endmodule
